// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Purpose  : 4-digit 7-segment scan generator with per-slot dead time and a
//            frame-synchronous display buffer. Define SEG_LZB_EN to enable
//            leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
  parameter int DIG_CYC  = 12000,
  parameter int DEAD_CYC = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic        data_load,
  output logic [1:0]  sel,
  output logic [3:0]  key,
  output logic        frame_done
);

  localparam int               CNT_W     = $clog2(DIG_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIG_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD  = CNT_W'(DEAD_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       KEY_BLANK = 4'd15;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       key_q, key_d;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      pend_data_q, pend_data_d;
  logic             pend_q, pend_d;

  logic             slot_end;
  logic             frame_end;
  logic [3:0]       nib;
  logic [3:0]       digit_code;
  logic             lz_blank;

  always_comb begin
    slot_end     = (cnt_q == CNT_LAST);
    frame_end    = slot_end && (sel_q == 2'd3);
    cnt_d        = slot_end ? '0 : cnt_q + CNT_ONE;
    sel_d        = slot_end ? sel_q + 2'd1 : sel_q;
    frame_done_d = frame_end;

    pend_data_d  = data_load ? data_in : pend_data_q;
    pend_d       = pend_q;
    shadow_d     = shadow_q;
    if (frame_end) begin
      // A load coinciding with the boundary bypasses the pending register.
      if (data_load) begin
        shadow_d = data_in;
        pend_d   = 1'b0;
      end else if (pend_q) begin
        shadow_d = pend_data_q;
        pend_d   = 1'b0;
      end
    end else if (data_load) begin
      pend_d = 1'b1;
    end

    // Key is computed from next-state values so sel and key switch together.
    case (sel_d)
      2'd0:    nib = shadow_d[3:0];
      2'd1:    nib = shadow_d[7:4];
      2'd2:    nib = shadow_d[11:8];
      default: nib = shadow_d[15:12];
    endcase
    digit_code = (nib > 4'd9) ? 4'd9 : nib;

`ifdef SEG_LZB_EN
    case (sel_d)
      2'd3:    lz_blank = (shadow_d[15:12] == 4'd0);
      2'd2:    lz_blank = (shadow_d[15:8]  == 8'd0);
      2'd1:    lz_blank = (shadow_d[15:4]  == 12'd0);
      default: lz_blank = 1'b0;
    endcase
`else
    lz_blank = 1'b0;
`endif

    key_d = ((cnt_d < CNT_DEAD) || lz_blank) ? KEY_BLANK : digit_code;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      sel_q        <= 2'd0;
      key_q        <= KEY_BLANK;
      frame_done_q <= 1'b0;
      shadow_q     <= 16'h0000;
      pend_data_q  <= 16'h0000;
      pend_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      key_q        <= key_d;
      frame_done_q <= frame_done_d;
      shadow_q     <= shadow_d;
      pend_data_q  <= pend_data_d;
      pend_q       <= pend_d;
    end
  end

  assign sel        = sel_q;
  assign key        = key_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Purpose  : Scoreboard bench for seg_scan_driver against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

  localparam int DIG   = 8;
  localparam int DEAD  = 2;
  localparam int FRAME = 4 * DIG;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] key;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic        data_load;
  logic [1:0]  sel;
  logic [3:0]  key;
  logic        frame_done;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Model state: cycles since reset release, displayed value, pending load.
  int          t;
  logic [15:0] shown;
  logic        pend_v;
  logic [15:0] pend_val;

  seg_scan_driver #(.DIG_CYC(DIG), .DEAD_CYC(DEAD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_load  (data_load),
    .sel        (sel),
    .key        (key),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic exp_t model_out(int tt, logic [15:0] val);
    exp_t e;
    int   slot = (tt / DIG) % 4;
    int   off  = tt % DIG;
    int   upper = int'(val) >> (4 * slot);
    int   nibv  = upper & 15;
    e.sel = 2'(slot);
    e.fd  = (tt > 0) && (tt % FRAME == 0);
    if (off < DEAD) e.key = 4'd15;
`ifdef SEG_LZB_EN
    else if (slot > 0 && upper == 0) e.key = 4'd15;
`endif
    else e.key = 4'((nibv > 9) ? 9 : nibv);
    return e;
  endfunction

  task automatic cyc(input logic r, input logic ld, input logic [15:0] d);
    rst_n     = r;
    data_load = ld;
    data_in   = d;
    if (!r) begin
      t = 0; shown = 16'h0; pend_v = 1'b0; pend_val = 16'h0;
    end else begin
      if ((t + 1) % FRAME == 0) begin
        if (ld) begin shown = d; pend_v = 1'b0; end
        else if (pend_v) begin shown = pend_val; pend_v = 1'b0; end
      end else if (ld) begin
        pend_v = 1'b1; pend_val = d;
      end
      t = t + 1;
    end
    @(posedge clk);
    exp_q.push_back(model_out(t, shown));
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 16'h0);
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) cyc(1'b1, 1'b0, 16'h0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (sel !== e.sel) begin
        failures++;
        $display("FAIL sel t=%0d actual=%0d required=%0d", $time, sel, e.sel);
      end
      checks++;
      if (key !== e.key) begin
        failures++;
        $display("FAIL key t=%0d sel=%0d actual=%0d required=%0d", $time, e.sel, key, e.key);
      end
      checks++;
      if (frame_done !== e.fd) begin
        failures++;
        $display("FAIL frame_done t=%0d actual=%0b required=%0b", $time, frame_done, e.fd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; data_load = 1'b0; data_in = 16'h0;
    t = 0; shown = 16'h0; pend_v = 1'b0; pend_val = 16'h0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0);
    idle(40);

    run_to(9);                       // sel==1, mid-frame load
    cyc(1'b1, 1'b1, 16'h1234);
    idle(2 * FRAME);

    cyc(1'b1, 1'b1, 16'hA0F9);
    idle(2 * FRAME);

    run_to(10);
    cyc(1'b1, 1'b1, 16'h1111);
    run_to(FRAME - 1);               // load exactly on the boundary edge
    cyc(1'b1, 1'b1, 16'h5678);
    idle(FRAME + 4);

    cyc(1'b1, 1'b1, 16'h0050);
    idle(2 * FRAME);
    cyc(1'b1, 1'b1, 16'h0000);
    idle(2 * FRAME);

    cyc(1'b1, 1'b1, 16'h4321);
    idle(FRAME);
    run_to(2 * DIG + 5);
    cyc(1'b0, 1'b0, 16'h0);
    idle(40);

    for (int i = 0; i < 800; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if ($urandom_range(0, 3) == 0) d[15:8] = 8'h00;
      if ($urandom_range(0, 299) == 0) cyc(1'b0, 1'b0, d);
      else cyc(1'b1, ($urandom_range(0, 9) == 0), d);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
